sssp_level_ctrl: RTL and testbench
==================================

// Module: sssp_level_ctrl
// PURPOSE
// Per-level sequencer for the SSSP relaxation pipelines. Issues vertex-block then edge-block
// cache-line reads and forwards responses to NPIPE pipelines with the matching control code.
// Waits for all pipelines to drain, counts relaxation updates, then advances current_level.
// Stops when a level produces zero updates or the level cap is reached.
// PARAMETERS
// NPIPE        4    number of pipelines driven (one per 128-bit edge slot)
// MAX_OUTST    64   max outstanding read requests (credit limit)
// CNT_W        32   width of line counters and update counter
// PORTS
// clk            in   1      clock
// rst            in   1      synchronous active-high reset
// start          in   1      pulse; begins a run from level 0 when in IDLE or DONE
// cfg_vtx_lines  in   CNT_W  vertex cache lines per level (loaded with control=1)
// cfg_edge_lines in   CNT_W  edge cache lines per level (processed with control=2)
// cfg_max_level  in   16     last level processed (inclusive)
// rd_req_valid   out  1      read request valid
// rd_req_ready   in   1      request accepted when valid&ready
// rd_req_kind    out  1      0 = vertex line, 1 = edge line
// rd_req_idx     out  CNT_W  line index within its region, 0-based
// rd_rsp_valid   in   1      response line valid (in request order, never stalled)
// pipe_word_valid out 1      word_in_valid to all pipelines (= rd_rsp_valid in LOAD/EDGE)
// pipe_control   out  2      0 idle, 1 load vertices, 2 process edges
// pipe_last_in   out  1      high with final edge response of the level
// pipe_level     out  16     current_level to all pipelines
// pipe_last_out  in   NPIPE  last_input_out from each pipeline
// pipe_valid_out in   NPIPE  valid_out from each pipeline
// busy           out  1      high in every state except IDLE and DONE
// done           out  1      high in DONE
// level_updates  out  CNT_W  updates counted in the most recent completed level
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters, credits, level cleared. Reset mid-run aborts.
// - States: IDLE, LOAD, EDGE, DRAIN, CHECK, DONE. All outputs registered.
// - IDLE/DONE + start -> LOAD with level=0, upd=0. start in any other state ignored.
// - LOAD: control=1; issue kind0 idx 0..cfg_vtx_lines-1; forward responses. When all vertex
//   responses received -> EDGE. cfg_vtx_lines==0 -> EDGE immediately.
// - EDGE: control=2; issue kind1 idx 0..cfg_edge_lines-1; pipe_last_in=1 on the response
//   completing the count. Next cycle -> DRAIN. cfg_edge_lines==0 -> CHECK, upd=0.
// - No vertex request issues until the previous level's DRAIN completes (phases never overlap).
// - Credits: request issues only if outstanding<MAX_OUTST; req+rsp same cycle nets 0.
// - rd_req_valid held with stable kind/idx until accepted; deasserts on the cycle after the
//   final accept of a phase.
// - DRAIN: control held 2, word_valid 0; per-pipe sticky seen bit set on pipe_last_out; exit
//   to CHECK the cycle after all seen bits are set.
// - Updates: upd += popcount(pipe_valid_out) every cycle in EDGE and DRAIN, including the
//   cycle a last_out arrives; saturate at all-ones.
// - CHECK (1 cycle): level_updates<=upd. If upd==0 or level==cfg_max_level -> DONE, else
//   level++, upd<=0, clear seen bits -> LOAD. Level compare prevents 16-bit wrap.
// - DONE: done=1, control=0, held until start or rst.
// - Response in IDLE/DONE/DRAIN/CHECK is a protocol error: dropped, never forwarded.
// STRUCTURE
// - sssp_ctrl_pkg: state enum; CTRL_IDLE=2'd0, CTRL_LOAD=2'd1, CTRL_EDGE=2'd2; REQ_VTX/REQ_EDGE.
// - Sub-module sssp_req_issuer: request index counter, response counter, credit counter.
//   Ports: phase start/count in; req handshake out; all_issued and all_received out.
//   Instantiated once and reused by LOAD and EDGE.
// - Top: FSM, drain tracker, popcount accumulator, output registers.
// TESTING
// - vtx=2, edge=3, max=5, pipes report 0 updates -> exactly 1 level; reqs v0,v1,e0,e1,e2;
//   pipe_last_in on 3rd edge rsp; done, level_updates=0.
// - Pipe model returns 2 valid_out per level for levels 0..2, then 0 -> pipe_level steps 0,1,2,3;
//   DONE after level 3; level_updates=0.
// - max=1, updates always nonzero -> DONE after level 1; level_updates = last level's count.
// - MAX_OUTST=2, responses delayed 10 cycles, edge=8 -> outstanding never exceeds 2; all idx 0..7
//   issued in order.
// - rd_req_ready low 5 cycles -> kind/idx held stable; no duplicate or skipped index.
// - edge=0 -> LOAD, CHECK, DONE with no edge requests; rst during EDGE -> IDLE, outputs 0;
//   a following start reruns from level 0.

Source files
------------

// File: rtl/sssp_ctrl_pkg.sv
// Shared types for the SSSP level sequencer: FSM states, pipeline control codes
// and read-request kinds.
package sssp_ctrl_pkg;

  localparam int unsigned LEVEL_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EDGE,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_LOAD = 2'd1,
    CTRL_EDGE = 2'd2
  } ctrl_e;

  typedef enum logic {
    REQ_VTX  = 1'b0,
    REQ_EDGE = 1'b1
  } req_kind_e;

endpackage

// File: rtl/sssp_req_issuer.sv
// Per-phase read issuer: walks line indices 0..count-1 under a credit limit and
// counts returning responses. Reused for the vertex and the edge phase.
module sssp_req_issuer #(
  parameter int unsigned MAX_OUTST = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_start_i,
  input  logic [CNT_W-1:0] phase_count_i,
  input  logic             active_i,
  input  logic             req_ready_i,
  input  logic             rsp_valid_i,
  output logic             req_valid_o,
  output logic [CNT_W-1:0] req_idx_o,
  output logic             all_issued_o,
  output logic             all_received_o,
  output logic             rsp_last_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
  localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUTST);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] rcv_q, rcv_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic             valid_q, valid_d;
  logic             fire, rsp_take;

  assign fire     = valid_q & req_ready_i;
  assign rsp_take = rsp_valid_i & (rcv_q != count_q);

  assign req_valid_o    = valid_q;
  assign req_idx_o      = issued_q;
  assign all_issued_o   = (issued_q == count_q);
  assign all_received_o = (rcv_q == count_q);
  assign rsp_last_o     = rsp_take & ((rcv_q + CNT_W'(1)) == count_q);

  always_comb begin
    issued_d = issued_q + (fire ? CNT_W'(1) : '0);
    rcv_d    = rcv_q + (rsp_take ? CNT_W'(1) : '0);
    outst_d  = outst_q;
    if (fire && !rsp_take) begin
      outst_d = outst_q + OUT_W'(1);
    end else if (!fire && rsp_take && (outst_q != '0)) begin
      outst_d = outst_q - OUT_W'(1);
    end
    // Valid is only raised against post-update credits, so once up it stays
    // up (with a stable index) until accepted.
    valid_d = active_i && (issued_d < count_q) && (outst_d < MAX_O);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      issued_q <= '0;
      rcv_q    <= '0;
      outst_q  <= '0;
      valid_q  <= 1'b0;
    end else if (phase_start_i) begin
      count_q  <= phase_count_i;
      issued_q <= '0;
      rcv_q    <= '0;
      outst_q  <= outst_d;
      valid_q  <= 1'b0;
    end else begin
      issued_q <= issued_d;
      rcv_q    <= rcv_d;
      outst_q  <= outst_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/sssp_level_ctrl.sv
// Level sequencer for the SSSP relaxation pipelines: vertex load, edge pass,
// pipeline drain and update check, repeated until convergence or the level cap.
module sssp_level_ctrl
  import sssp_ctrl_pkg::*;
#(
  parameter int unsigned NPIPE     = 4,
  parameter int unsigned MAX_OUTST = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_vtx_lines,
  input  logic [CNT_W-1:0]   cfg_edge_lines,
  input  logic [LEVEL_W-1:0] cfg_max_level,
  output logic               rd_req_valid,
  input  logic               rd_req_ready,
  output logic               rd_req_kind,
  output logic [CNT_W-1:0]   rd_req_idx,
  input  logic               rd_rsp_valid,
  output logic               pipe_word_valid,
  output logic [1:0]         pipe_control,
  output logic               pipe_last_in,
  output logic [LEVEL_W-1:0] pipe_level,
  input  logic [NPIPE-1:0]   pipe_last_out,
  input  logic [NPIPE-1:0]   pipe_valid_out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   level_updates
);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   upd_q, upd_d;
  logic [CNT_W-1:0]   lvl_upd_q, lvl_upd_d;
  logic [NPIPE-1:0]   seen_q, seen_d;
  req_kind_e          kind_q, kind_d;
  ctrl_e              ctrl_q, ctrl_d;
  logic               wv_q, wv_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               phase_start;
  logic [CNT_W-1:0]   phase_count;
  logic               in_phase;
  logic               rsp_in;
  logic               all_issued, all_received, rsp_last;
  logic [CNT_W-1:0]   pcnt, upd_acc;
  logic [CNT_W:0]     upd_sum;

  assign in_phase    = (state_q == S_LOAD) || (state_q == S_EDGE);
  assign rsp_in      = rd_rsp_valid & in_phase;
  assign phase_start = (state_d != state_q) && ((state_d == S_LOAD) || (state_d == S_EDGE));
  assign phase_count = (state_d == S_LOAD) ? cfg_vtx_lines : cfg_edge_lines;

  sssp_req_issuer #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_issuer (
    .clk            (clk),
    .rst            (rst),
    .phase_start_i  (phase_start),
    .phase_count_i  (phase_count),
    .active_i       (in_phase),
    .req_ready_i    (rd_req_ready),
    .rsp_valid_i    (rsp_in),
    .req_valid_o    (rd_req_valid),
    .req_idx_o      (rd_req_idx),
    .all_issued_o   (all_issued),
    .all_received_o (all_received),
    .rsp_last_o     (rsp_last)
  );

  always_comb begin
    pcnt = '0;
    for (int unsigned i = 0; i < NPIPE; i++) begin
      pcnt = pcnt + CNT_W'(pipe_valid_out[i]);
    end
    upd_sum = {1'b0, upd_q} + {1'b0, pcnt};
    upd_acc = upd_sum[CNT_W] ? '1 : upd_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    upd_d     = upd_q;
    lvl_upd_d = lvl_upd_q;
    seen_d    = seen_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          level_d = '0;
          upd_d   = '0;
          seen_d  = '0;
        end
      end
      // Vertex phase waits on the registered count so the last vertex word
      // still goes out with the load control code.
      S_LOAD: begin
        if (all_issued && all_received) state_d = S_EDGE;
      end
      S_EDGE: begin
        upd_d = upd_acc;
        if (all_received) begin
          state_d = S_CHECK;
          upd_d   = '0;
        end else if (rsp_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        upd_d  = upd_acc;
        seen_d = seen_q | pipe_last_out;
        if (&seen_q) state_d = S_CHECK;
      end
      S_CHECK: begin
        lvl_upd_d = upd_q;
        if ((upd_q == '0) || (level_q == cfg_max_level)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
          level_d = level_q + LEVEL_W'(1);
          upd_d   = '0;
          seen_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    kind_d = kind_q;
    if (phase_start) kind_d = (state_d == S_EDGE) ? REQ_EDGE : REQ_VTX;
    ctrl_d = CTRL_IDLE;
    if (state_d == S_LOAD) begin
      ctrl_d = CTRL_LOAD;
    end else if ((state_d == S_EDGE) || (state_d == S_DRAIN)) begin
      ctrl_d = CTRL_EDGE;
    end
    wv_d   = rsp_in;
    last_d = (state_q == S_EDGE) && rsp_last;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      level_q   <= '0;
      upd_q     <= '0;
      lvl_upd_q <= '0;
      seen_q    <= '0;
      kind_q    <= REQ_VTX;
      ctrl_q    <= CTRL_IDLE;
      wv_q      <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      upd_q     <= upd_d;
      lvl_upd_q <= lvl_upd_d;
      seen_q    <= seen_d;
      kind_q    <= kind_d;
      ctrl_q    <= ctrl_d;
      wv_q      <= wv_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_req_kind     = kind_q;
  assign pipe_control    = ctrl_q;
  assign pipe_word_valid = wv_q;
  assign pipe_last_in    = last_q;
  assign pipe_level      = level_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign level_updates   = lvl_upd_q;

endmodule

// File: tb/tb_sssp_level_ctrl.sv
// Bench for sssp_level_ctrl: memory and pipeline models around the DUT, with
// request and forwarded-word expectations queued and checked as the DUT responds.
module tb_sssp_level_ctrl;

  localparam int unsigned NPIPE     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned CNT_W     = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_vtx_lines = '0;
  logic [CNT_W-1:0] cfg_edge_lines = '0;
  logic [15:0]      cfg_max_level = '0;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic             rd_req_kind;
  logic [CNT_W-1:0] rd_req_idx;
  logic             rd_rsp_valid;
  logic             pipe_word_valid;
  logic [1:0]       pipe_control;
  logic             pipe_last_in;
  logic [15:0]      pipe_level;
  logic [NPIPE-1:0] pipe_last_out;
  logic [NPIPE-1:0] pipe_valid_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] level_updates;

  always #5 clk = ~clk;

  sssp_level_ctrl #(
    .NPIPE     (NPIPE),
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_vtx_lines  (cfg_vtx_lines),
    .cfg_edge_lines (cfg_edge_lines),
    .cfg_max_level  (cfg_max_level),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_kind    (rd_req_kind),
    .rd_req_idx     (rd_req_idx),
    .rd_rsp_valid   (rd_rsp_valid),
    .pipe_word_valid(pipe_word_valid),
    .pipe_control   (pipe_control),
    .pipe_last_in   (pipe_last_in),
    .pipe_level     (pipe_level),
    .pipe_last_out  (pipe_last_out),
    .pipe_valid_out (pipe_valid_out),
    .busy           (busy),
    .done           (done),
    .level_updates  (level_updates)
  );

  typedef struct {
    int unsigned due;
    logic        kind;
  } pend_t;

  typedef struct {
    logic [1:0]  ctl;
    logic        last;
    logic [15:0] lvl;
  } fwd_t;

  logic [32:0] exp_req[$];
  pend_t       pend_q[$];
  fwd_t        fwd_q[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Stimulus configuration, written only by the main sequence.
  int unsigned upd_tab[16];
  logic [3:0]  vmask = 4'b0001;
  int unsigned rsp_dly = 1;
  int unsigned cfg_e = 0;
  int          stall_at = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory + pipeline model; all its state is owned by this process.
  initial begin
    int unsigned cyc = 0;
    int          outst = 0;
    int          run_fires = 0;
    int unsigned stall_cnt = 0;
    bit          stall_done = 0;
    bit          prev_stalled = 0;
    logic [32:0] prev_ki = '0;
    bit          drain_active = 0;
    int unsigned drain_t = 0, drain_u = 0;
    int unsigned cur_lvl = 0, edge_rsps = 0;
    fwd_t        f;
    pend_t       p;
    logic [32:0] e;
    rd_req_ready   = 1'b1;
    rd_rsp_valid   = 1'b0;
    pipe_last_out  = '0;
    pipe_valid_out = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_req.delete(); pend_q.delete(); fwd_q.delete();
        outst = 0; run_fires = 0; stall_cnt = 0; stall_done = 0; prev_stalled = 0;
        drain_active = 0; cur_lvl = 0; edge_rsps = 0;
        rd_req_ready = 1'b1; rd_rsp_valid = 1'b0;
        pipe_last_out = '0; pipe_valid_out = '0;
        continue;
      end
      if (!busy) begin
        cur_lvl = 0; edge_rsps = 0; run_fires = 0; stall_done = 0;
      end

      if (fwd_q.size() > 0) begin
        f = fwd_q.pop_front();
        check_eq("fwd_valid", pipe_word_valid, 1);
        check_eq("fwd_ctrl", pipe_control, f.ctl);
        check_eq("fwd_last", pipe_last_in, f.last);
        check_eq("fwd_level", pipe_level, f.lvl);
      end else begin
        check_eq("no_fwd", {pipe_word_valid, pipe_last_in}, 0);
      end
      if (pipe_word_valid && pipe_last_in) begin
        drain_active = 1; drain_t = 0; drain_u = upd_tab[cur_lvl]; cur_lvl++;
      end

      pipe_valid_out = '0;
      pipe_last_out  = '0;
      if (drain_active) begin
        drain_t++;
        if (drain_t <= drain_u) pipe_valid_out = vmask;
        for (int unsigned i = 0; i < NPIPE; i++)
          if (drain_t == drain_u + 1 + i) pipe_last_out[i] = 1'b1;
        if (drain_t >= drain_u + NPIPE) drain_active = 0;
      end

      if (prev_stalled) begin
        check_eq("hold_valid", rd_req_valid, 1);
        check_eq("hold_req", {rd_req_kind, rd_req_idx}, prev_ki);
      end
      if (stall_cnt > 0) stall_cnt--;
      if (!stall_done && stall_at >= 0 && run_fires == stall_at) begin
        stall_cnt = 5; stall_done = 1;
      end
      rd_req_ready = (stall_cnt == 0);

      rd_rsp_valid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        rd_rsp_valid = 1'b1;
        outst--;
        f.ctl  = p.kind ? 2'd2 : 2'd1;
        f.last = 1'b0;
        if (p.kind) begin
          edge_rsps++;
          if (edge_rsps == cfg_e) begin f.last = 1'b1; edge_rsps = 0; end
        end
        f.lvl = 16'(cur_lvl);
        fwd_q.push_back(f);
      end

      if (rd_req_valid && rd_req_ready) begin
        run_fires++;
        outst++;
        check_eq("credit", outst <= int'(MAX_OUTST), 1);
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front();
          check_eq("req", {rd_req_kind, rd_req_idx}, e);
        end else begin
          check_eq("req_extra", rd_req_valid, 0);
        end
        p.due  = cyc + rsp_dly;
        p.kind = rd_req_kind;
        pend_q.push_back(p);
      end
      prev_stalled = rd_req_valid && !rd_req_ready;
      prev_ki      = {rd_req_kind, rd_req_idx};
    end
  end

  task automatic push_level(input int unsigned v, input int unsigned e);
    for (int unsigned i = 0; i < v; i++) exp_req.push_back({1'b0, 32'(i)});
    for (int unsigned i = 0; i < e; i++) exp_req.push_back({1'b1, 32'(i)});
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run(input int unsigned v, input int unsigned e, input int unsigned mx,
                     input int unsigned dly, input int st);
    int unsigned lvl = 0, u = 0, k = 0;
    cfg_vtx_lines = v; cfg_edge_lines = e; cfg_max_level = 16'(mx);
    cfg_e = e; rsp_dly = dly; stall_at = st;
    forever begin
      u = (e == 0) ? 0 : upd_tab[lvl] * $countones(vmask);
      push_level(v, e);
      if (u == 0 || lvl == mx) break;
      lvl++;
    end
    pulse_start();
    while (!done && k < 20000) begin @(negedge clk); k++; end
    check_eq("done", done, 1);
    check_eq("busy_done", busy, 0);
    check_eq("ctrl_done", pipe_control, 0);
    check_eq("level_updates", level_updates, u);
    check_eq("final_level", pipe_level, lvl);
    check_eq("reqs_left", exp_req.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_outs", {rd_req_valid, rd_req_kind, rd_req_idx, pipe_word_valid,
                          pipe_control, pipe_last_in, pipe_level}, 0);
    check_eq("rst_status", {busy, done, level_updates}, 0);
  endtask

  initial begin
    int unsigned k;
    foreach (upd_tab[i]) upd_tab[i] = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single level: pipes report no updates.
    run(2, 3, 5, 1, -1);

    // Three productive levels, the fourth converges.
    upd_tab[0] = 2; upd_tab[1] = 2; upd_tab[2] = 2; upd_tab[3] = 0;
    vmask = 4'b0001;
    run(2, 3, 5, 1, -1);

    // Level cap stops an always-productive run after level 1.
    upd_tab[0] = 3; upd_tab[1] = 1; upd_tab[2] = 1;
    vmask = 4'b1011;
    run(1, 2, 1, 1, -1);

    // Credit limit with slow responses.
    foreach (upd_tab[i]) upd_tab[i] = 0;
    run(1, 8, 5, 10, -1);

    // Request stalled by rd_req_ready low for 5 cycles.
    run(2, 4, 3, 1, 3);

    // No edge lines: load, check, done.
    upd_tab[0] = 4;
    run(3, 0, 5, 1, -1);
    upd_tab[0] = 0;

    // Reset in the middle of the edge phase, then a clean rerun.
    cfg_vtx_lines = 2; cfg_edge_lines = 8; cfg_max_level = 5;
    cfg_e = 8; rsp_dly = 10; stall_at = -1;
    push_level(2, 8);
    pulse_start();
    k = 0;
    while (!(rd_req_valid && rd_req_kind) && k < 2000) begin @(negedge clk); k++; end
    check_eq("edge_reached", rd_req_kind, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(2, 3, 5, 1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
